fma_pipe: RTL and testbench

Parametrised, pipelined fused multiply-add/accumulate processing element for the TPU datapath. It computes `a + b*c` or `acc + b*c` with signed or unsigned operands selected per beat. The internal accumulator allows back-to-back dot-product chains, and overflow is detected in full precision. It sits between the operand feeders and the result collector behind valid/ready handshakes, and can be instantiated per systolic-array column.

---
 rtl/fma_pipe.sv | 102 ++++++++++
 tb/tb_fma_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fma_pipe.sv
// Two-stage fused multiply-add/accumulate PE: result = (acc ? acc_q : a) + b*c, per-beat signedness.
// Define FMA_SATURATE_EN to clamp overflowing results (and the accumulator) instead of wrapping.
module fma_pipe #(
  parameter int OP_W  = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic [OP_W-1:0]  in_c,
  input  logic             in_signed,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_result,
  output logic             out_ovf
);
  localparam int P_W = 2*OP_W;
  localparam int X_W = ACC_W+2;

  typedef struct packed {
    logic [ACC_W-1:0] a;
    logic [P_W-1:0]   prod;
    logic             sgn;
    logic             acc;
  } s1_t;

  s1_t              s1_q, s1_d;
  logic             s1_valid;
  logic [ACC_W-1:0] acc_q;
  logic             adv;

  // Operands extended to the product width so a plain low-half multiply is exact for both modes.
  logic [P_W-1:0] b_ext, c_ext;
  assign b_ext = {{OP_W{in_signed & in_b[OP_W-1]}}, in_b};
  assign c_ext = {{OP_W{in_signed & in_c[OP_W-1]}}, in_c};

  always_comb begin
    s1_d      = '0;
    s1_d.a    = in_a;
    s1_d.prod = b_ext * c_ext;
    s1_d.sgn  = in_signed;
    s1_d.acc  = in_acc;
  end

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv || !s1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // S2: exact sum at ACC_W+2 bits, then range check under the beat's signedness.
  logic [ACC_W-1:0] addend;
  logic [X_W-1:0]   prod_x, add_x, sum;
  logic             ovf;
  logic [ACC_W-1:0] res;

  always_comb begin
    addend = s1_q.acc ? acc_q : s1_q.a;
    prod_x = {{(X_W-P_W){s1_q.sgn & s1_q.prod[P_W-1]}}, s1_q.prod};
    add_x  = {{2{s1_q.sgn & addend[ACC_W-1]}}, addend};
    sum    = prod_x + add_x;
    if (s1_q.sgn)
      ovf = !((sum[X_W-1:ACC_W-1] == 3'b000) || (sum[X_W-1:ACC_W-1] == 3'b111));
    else
      ovf = |sum[X_W-1:ACC_W];
    res = sum[ACC_W-1:0];
`ifdef FMA_SATURATE_EN
    if (ovf) begin
      if (!s1_q.sgn)         res = '1;
      else if (sum[X_W-1])   res = {1'b1, {(ACC_W-1){1'b0}}};
      else                   res = {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      acc_q      <= '0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res;
        out_ovf    <= ovf;
        acc_q      <= res;
      end
    end
  end
endmodule

// File: tb/tb_fma_pipe.sv
// Directed bench for fma_pipe (OP_W=8, ACC_W=16): hand-computed vectors checked with immediate assertions.
module tb_fma_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_a;
  logic [7:0]  in_b, in_c;
  logic        in_signed, in_acc;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  fma_pipe #(.OP_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_signed(in_signed), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic s, input logic acc);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_c      = c;
    in_signed = s;
    in_acc    = acc;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    in_signed = 1'b0; in_acc = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    step();

    // unsigned multiply-add: 100 + 200*3 = 700
    drive(16'd100, 8'd200, 8'd3, 1'b0, 1'b0);
    chk("mad_in_ready", in_ready, 1);
    step(); in_valid = 1'b0;
    chk("mad_lat_not_yet", out_valid, 0);
    step();
    chk("mad_valid", out_valid, 1);
    chk("mad_result", out_result, 16'h02BC);
    chk("mad_ovf", out_ovf, 0);
    step();
    chk("mad_drained", out_valid, 0);

    // signed vs unsigned interpretation of b = 0xFC
    drive(16'h0003, 8'hFC, 8'd5, 1'b1, 1'b0);
    step();
    drive(16'h0003, 8'hFC, 8'd5, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    chk("sgn_result", out_result, 16'hFFEF);
    chk("sgn_ovf", out_ovf, 0);
    step();
    chk("uns_valid", out_valid, 1);
    chk("uns_result", out_result, 16'h04EF);
    chk("uns_ovf", out_ovf, 0);
    step();

    // back-to-back signed accumulate chain: 16, 36, 35
    drive(16'd10, 8'd2, 8'd3, 1'b1, 1'b0);
    step();
    drive(16'd0, 8'd4, 8'd5, 1'b1, 1'b1);
    step();
    chk("chain0_valid", out_valid, 1);
    chk("chain0", out_result, 16);
    drive(16'd0, 8'hFF, 8'd1, 1'b1, 1'b1);
    step(); in_valid = 1'b0;
    chk("chain1", out_result, 36);
    step();
    chk("chain2_valid", out_valid, 1);
    chk("chain2", out_result, 35);
    step();

    // overflow in both signedness modes
    drive(16'hFFFF, 8'd1, 8'd1, 1'b0, 1'b0);
    step();
    drive(16'h7FFF, 8'd1, 8'd1, 1'b1, 1'b0);
    step(); in_valid = 1'b0;
    chk("uovf_flag", out_ovf, 1);
`ifdef FMA_SATURATE_EN
    chk("uovf_result", out_result, 16'hFFFF);
`else
    chk("uovf_result", out_result, 16'h0000);
`endif
    step();
    chk("sovf_flag", out_ovf, 1);
`ifdef FMA_SATURATE_EN
    chk("sovf_result", out_result, 16'h7FFF);
`else
    chk("sovf_result", out_result, 16'h8000);
`endif
    step();
    chk("post_ovf_idle", out_valid, 0);

    // backpressure: only two beats fit, result held, then drained in order
    out_ready = 1'b0;
    drive(16'd1, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("bp_rdy1", in_ready, 1);
    step();
    drive(16'd2, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("bp_rdy2", in_ready, 1);
    step();
    drive(16'd3, 8'd0, 8'd0, 1'b0, 1'b0);
    chk("bp_full_rdy", in_ready, 0);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold1", out_result, 1);
    step();
    chk("bp_still_full", in_ready, 0);
    chk("bp_hold2", out_result, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", in_ready, 1);
    step();
    chk("bp_out2", out_result, 2);
    drive(16'd4, 8'd0, 8'd0, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    chk("bp_out3", out_result, 3);
    step();
    chk("bp_out4_valid", out_valid, 1);
    chk("bp_out4", out_result, 4);
    step();
    chk("bp_empty", out_valid, 0);

    // asynchronous reset with both stages full
    out_ready = 1'b0;
    drive(16'd7, 8'd0, 8'd0, 1'b0, 1'b0);
    step();
    drive(16'd8, 8'd0, 8'd0, 1'b0, 1'b0);
    step(); in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_result", out_result, 0);
    chk("arst_acc_q", dut.acc_q, 0);
    chk("arst_in_ready", in_ready, 1);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post_rst_idle", out_valid, 0);
    drive(16'hABCD, 8'd2, 8'd3, 1'b1, 1'b1);
    step(); in_valid = 1'b0;
    step();
    chk("post_rst_acc_valid", out_valid, 1);
    chk("post_rst_acc", out_result, 6);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
